// File: rtl/conv_seq_pkg.sv
// Shared definitions for the stage sequencers: FSM encoding, tag widths and frame defaults.
// Imported by the dataflow top and the DW weight selector so tag widths agree.
package conv_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

   localparam int CNT_W          = 5;
   localparam int POS_W          = 4;
   localparam int DEF_CNT_MAX    = 32;
   localparam int DEF_POS_MAX    = 9;
   localparam int DEF_PIPE_DEPTH = 2;
   localparam int TOKENS         = DEF_CNT_MAX * DEF_POS_MAX;

   // True when the tag pair is the final token of a frame.
   function automatic logic tag_is_last(input logic [CNT_W-1:0] cnt,
                                        input logic [POS_W-1:0] pos,
                                        input int               cnt_max,
                                        input int               pos_max);
      return (cnt == CNT_W'(cnt_max - 1)) && (pos == POS_W'(pos_max - 1));
   endfunction

endpackage

// File: rtl/valid_pipe.sv
// Enable-gated valid shift register tracking which datapath slots hold real tokens.
// Shared by the stage sequencers; cleared asynchronously by rst_b.
module valid_pipe #(
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             en,
   input  logic             din,
   output logic [DEPTH-1:0] v
);

   logic [DEPTH-1:0] v_r;

   // Shift a new valid bit in on every enabled cycle, hold otherwise.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         v_r <= '0;
      end else if (en) begin
         v_r[0] <= din;
         for (int k = 1; k < DEPTH; k++) begin
            v_r[k] <= v_r[k-1];
         end
      end else begin
         v_r <= v_r;
      end
   end

   assign v = v_r;

endmodule

// File: rtl/conv_act_sequencer.sv
// Frame sequencer for the convolution-activation stage: issues (pos, cnt) tags,
// drives the global pipeline enable and reports completion after the pipeline drains.
module conv_act_sequencer
   import conv_seq_pkg::*;
#(
   parameter int CNT_MAX    = DEF_CNT_MAX,
   parameter int POS_MAX    = DEF_POS_MAX,
   parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [CNT_W-1:0] cnt_in,
   output logic [POS_W-1:0] pos_in,
   output logic             en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done
);

   seq_state_e            state_r;
   seq_state_e            state_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [POS_W-1:0]      pos_r;
   logic [PIPE_DEPTH-1:0] v_s;
   logic                  en_s;
   logic                  in_ready_s;
   logic                  fire_s;
   logic                  last_s;
   logic                  done_r;
   logic                  busy_r;

   // Enable, acceptance and fire qualification; bubbles in the last slot always advance.
   always_comb begin
      en_s       = !v_s[PIPE_DEPTH-1] || out_ready;
      in_ready_s = (state_r == ST_RUN) && en_s;
      fire_s     = in_valid && in_ready_s;
      last_s     = fire_s && tag_is_last(cnt_r, pos_r, CNT_MAX, POS_MAX);
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_RUN;
            else       state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (last_s) state_s = ST_DRAIN;
            else        state_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (v_s == '0) state_s = ST_DONE;
            else           state_s = ST_DRAIN;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Tag counters: pos outer, cnt inner, advancing only on a fire.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_r <= '0;
         pos_r <= '0;
      end else if ((state_r == ST_IDLE) && start) begin
         cnt_r <= '0;
         pos_r <= '0;
      end else if (fire_s) begin
         if (cnt_r == CNT_W'(CNT_MAX - 1)) begin
            cnt_r <= '0;
            // Wrap pos after the final token so an idle sequencer shows (0,0).
            if (pos_r == POS_W'(POS_MAX - 1)) pos_r <= '0;
            else                              pos_r <= pos_r + POS_W'(1);
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
            pos_r <= pos_r;
         end
      end else begin
         cnt_r <= cnt_r;
         pos_r <= pos_r;
      end
   end

   // Status flags registered from the next state so they track the state exactly.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         done_r <= (state_s == ST_DONE);
         busy_r <= (state_s != ST_IDLE);
      end
   end

   valid_pipe #(
      .DEPTH (PIPE_DEPTH)
   ) u_valid_pipe (
      .clk   (clk),
      .rst_b (rst_b),
      .en    (en_s),
      .din   (fire_s),
      .v     (v_s)
   );

   assign in_ready  = in_ready_s;
   assign en        = en_s;
   assign out_valid = v_s[PIPE_DEPTH-1];
   assign cnt_in    = cnt_r;
   assign pos_in    = pos_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: doc/conv_act_sequencer.md
# conv_act_sequencer

Sequencer for the convolution-activation stage, which has 16 rescale/ReLU lanes, a two-register pipeline and the depthwise weight selector. It walks the stage through one frame of 9 window positions × 32 channel steps by issuing the (pos, cnt) tag sequence. It drives the stage's single global `en`, so the whole pipeline stalls on downstream backpressure. It tracks which pipeline slots hold real data and reports frame completion once the pipeline has drained.

## Interface
Parameters:
- `CNT_MAX`, default 32: channel steps per position; `cnt` runs 0..CNT_MAX-1.
- `POS_MAX`, default 9: window positions per frame; `pos` runs 0..POS_MAX-1.
- `PIPE_DEPTH`, default 2: register stages in the controlled datapath.

Ports:
- `clk`, input, 1 bit: clock.
- `rst_b`, input, 1 bit: reset, asynchronous, active-low.
- `start`, input, 1 bit: frame start pulse; honoured only in IDLE.
- `in_valid`, input, 1 bit: upstream accumulator data is present on the datapath input.
- `in_ready`, output, 1 bit: the sequencer accepts the current input this cycle.
- `cnt_in`, output, 5 bits: channel tag driven to the datapath.
- `pos_in`, output, 4 bits: position tag driven to the datapath.
- `en`, output, 1 bit: datapath pipeline advance.
- `out_valid`, output, 1 bit: datapath `output_data`, `cnt_out` and `pos_out` hold a real token.
- `out_ready`, input, 1 bit: downstream accepts the output.
- `busy`, output, 1 bit: state is not IDLE.
- `done`, output, 1 bit: one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN on `start`; this transition clears `cnt` and `pos` to 0.
  - RUN to DRAIN on the fire of the last token (pos = POS_MAX-1, cnt = CNT_MAX-1).
  - DRAIN to DONE when all valid bits are 0.
  - DONE to IDLE unconditionally.
- `start` outside IDLE is ignored.
- Pipeline advance: `en` = !v[PIPE_DEPTH-1] || `out_ready` (combinational). Bubbles always advance.
- Acceptance: `in_ready` = (state == RUN) && `en`. A fire is `in_valid` && `in_ready`.
- Valid shift register v[0..PIPE_DEPTH-1]:
  - When `en` is high: v[0] ← fire, v[k] ← v[k-1].
  - When `en` is low: v holds.
- `out_valid` = v[PIPE_DEPTH-1].
- Tag outputs: `cnt_in` and `pos_in` are driven directly from the counter registers and advance only on a fire.
  - cnt increments on each fire.
  - At CNT_MAX-1, cnt wraps to 0 and pos increments.
- Tag order: pos outer, cnt inner, giving POS_MAX × CNT_MAX = 288 tokens per frame.
- `done` is registered and high exactly while the state is DONE.
- `busy` is 1 in RUN, DRAIN and DONE.

## Timing
- Reset values:
  - state IDLE; `cnt` = 0, `pos` = 0; v all 0.
  - `done`, `busy`, `in_ready` and `out_valid` are 0.
  - `en` is 1, because v is empty.
- Latency: a token that fires in cycle t appears with `out_valid` = 1 in cycle t+PIPE_DEPTH when `en` stays high. Every cycle with `en` low adds one cycle.
- Full pipeline with `out_ready` = 0: `en` = 0, so `in_ready` = 0 and all of v and the datapath registers hold.
- Empty pipeline with `out_ready` = 0: `en` = 1, so inputs are still accepted until v[PIPE_DEPTH-1] fills.
- A simultaneous output accept and input fire is legal and gives full throughput.
- Reference run, with `start` in cycle 0 and `in_valid` = `out_ready` = 1:
  - fires occur in cycles 1..288;
  - `out_valid` is high in cycles 3..290;
  - DRAIN covers cycles 289..291;
  - `done` pulses in cycle 292;
  - the state is IDLE in cycle 293.
- Reset mid-frame clears everything asynchronously. Any partial frame is discarded with no `done`.

## Structure
- Shared header/package `conv_seq_pkg` holds:
  - state encodings (2-bit);
  - CNT_W = 5 and POS_W = 4;
  - the defaults CNT_MAX = 32, POS_MAX = 9 and TOKENS = 288, so the dataflow top and the DW weight selector agree on tag widths.
- One sub-module, `valid_pipe`: a PIPE_DEPTH-deep enable-gated valid shift register with an async active-low clear. It is reused by the other stage sequencers.
- The FSM and the counters stay in the top module.

## Test plan
- Reset then idle: `start` = 0 for 10 cycles → `busy` = 0, `in_ready` = 0, `en` = 1, `cnt_in` = 0, `pos_in` = 0.
- Full-rate frame (start in cycle 0, `in_valid` = `out_ready` = 1):
  - 288 outputs, tags (0,0)…(8,31) in order;
  - `done` for exactly 1 cycle at cycle 292.
- Backpressure: `out_ready` = 0 for cycles 10–19 →
  - `en` = 0 and `in_ready` = 0 from cycle 10;
  - the tags hold and no token is lost or duplicated;
  - `done` is delayed by 10 cycles.
- Input bubbles: `in_valid` toggles every cycle → cnt advances only on fires and `out_valid` has a matching bubble pattern; 288 outputs in total.
- Wrap and stray start: check that tag (pos=0, cnt=31) is followed by (1,0); a `start` pulse during RUN has no effect.
- Mid-frame reset: assert `rst_b` = 0 at fire 100 →
  - all outputs at reset values immediately;
  - after release and a new `start`, the frame restarts at (0,0) and completes with 288 outputs.
